// File: rtl/li_expander.sv
// Load-immediate expander: turns a 32-bit constant plus destination register
// into one or two MIPS I-type words (addiu / ori / lui / lui+ori).
module li_expander #(
  parameter int ALLOW_ADDIU = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [4:0]  in_rt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic [1:0]  out_kind,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    EMIT_FIRST  = 2'd1,
    EMIT_SECOND = 2'd2
  } state_t;

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  state_t      state_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic        last_q;
  logic [1:0]  kind_q;
  logic [15:0] count_q;
  logic [4:0]  rt_q;
  logic [15:0] lo_q;

  logic        sext_fits;
  logic [1:0]  kind_d;
  logic [31:0] first_d;
  logic [31:0] second_d;
  logic [15:0] count_d;
  logic        accept;
  logic        handoff;

  // addiu sign-extends its immediate, so bits 31..15 must all match
  assign sext_fits = (&in_value[31:15]) | ~(|in_value[31:15]);
  assign accept    = in_valid && (state_q == IDLE);
  assign handoff   = valid_q && out_ready;
  assign count_d   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
  assign second_d  = {OP_ORI, rt_q, rt_q, lo_q};

  always_comb begin
    kind_d = 2'd3;
    if ((ALLOW_ADDIU != 0) && sext_fits) kind_d = 2'd0;
    else if (in_value[31:16] == 16'h0000) kind_d = 2'd1;
    else if (in_value[15:0] == 16'h0000)  kind_d = 2'd2;
  end

  always_comb begin
    first_d = {OP_LUI, 5'd0, in_rt, in_value[31:16]};
    case (kind_d)
      2'd0:    first_d = {OP_ADDIU, 5'd0, in_rt, in_value[15:0]};
      2'd1:    first_d = {OP_ORI, 5'd0, in_rt, in_value[15:0]};
      default: first_d = {OP_LUI, 5'd0, in_rt, in_value[31:16]};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      last_q  <= 1'b0;
      kind_q  <= 2'd0;
      count_q <= 16'h0;
      rt_q    <= 5'd0;
      lo_q    <= 16'h0;
    end else begin
      case (state_q)
        IDLE: begin
          // requests targeting $zero are swallowed without output
          if (accept && (in_rt != 5'd0)) begin
            state_q <= EMIT_FIRST;
            valid_q <= 1'b1;
            instr_q <= first_d;
            last_q  <= (kind_d != 2'd3);
            kind_q  <= kind_d;
            rt_q    <= in_rt;
            lo_q    <= in_value[15:0];
          end
        end
        EMIT_FIRST: begin
          if (handoff) begin
            count_q <= count_d;
            if (kind_q == 2'd3) begin
              state_q <= EMIT_SECOND;
              instr_q <= second_d;
              last_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        EMIT_SECOND: begin
          if (handoff) begin
            count_q <= count_d;
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = valid_q;
  assign out_instr  = instr_q;
  assign out_last   = last_q;
  assign out_kind   = kind_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_li_expander.sv
// Directed bench for li_expander: a vector table for single requests plus
// hand-written stall, $zero-target, ALLOW_ADDIU=0 and mid-sequence reset cases.
module tb_li_expander;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [31:0] in_value, out_instr;
  logic [4:0]  in_rt;
  logic [1:0]  out_kind;
  logic [15:0] word_count;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
  logic [31:0] in_value2, out_instr2;
  logic [4:0]  in_rt2;
  logic [1:0]  out_kind2;
  logic [15:0] word_count2;

  int n_cmp = 0;
  int n_err = 0;
  int exp_count = 0;

  typedef struct {
    logic [31:0] value;
    logic [4:0]  rt;
    logic [1:0]  kind;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  vec_t vecs[10];

  li_expander u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_rt(in_rt),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_last(out_last), .out_kind(out_kind), .word_count(word_count)
  );

  li_expander #(.ALLOW_ADDIU(0)) u_dut_noaddiu (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_value(in_value2), .in_rt(in_rt2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
    .out_last(out_last2), .out_kind(out_kind2), .word_count(word_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // entered right after a falling edge; leaves DUT idle, right after a falling edge
  task automatic run_vec(input int idx, input vec_t v);
    in_valid = 1'b1;
    in_value = v.value;
    in_rt    = v.rt;
    chk($sformatf("v%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("v%0d_valid1", idx), {31'd0, out_valid}, 32'd1);
    chk($sformatf("v%0d_instr1", idx), out_instr, v.w1);
    chk($sformatf("v%0d_kind", idx), {30'd0, out_kind}, {30'd0, v.kind});
    chk($sformatf("v%0d_last1", idx), {31'd0, out_last}, (v.kind == 2'd3) ? 32'd0 : 32'd1);
    chk($sformatf("v%0d_busy", idx), {31'd0, in_ready}, 32'd0);
    exp_count++;
    if (v.kind == 2'd3) begin
      @(negedge clk);
      chk($sformatf("v%0d_valid2", idx), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_instr2", idx), out_instr, v.w2);
      chk($sformatf("v%0d_last2", idx), {31'd0, out_last}, 32'd1);
      exp_count++;
    end
    @(negedge clk);
    chk($sformatf("v%0d_idle_valid", idx), {31'd0, out_valid}, 32'd0);
    chk($sformatf("v%0d_count", idx), {16'd0, word_count}, exp_count);
    chk($sformatf("v%0d_idle_ready", idx), {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'hFFFF8000, 5'd8,  2'd0, 32'h24088000, 32'h0};
    vecs[1] = '{32'h0000ABCD, 5'd9,  2'd1, 32'h3409ABCD, 32'h0};
    vecs[2] = '{32'h12340000, 5'd10, 2'd2, 32'h3C0A1234, 32'h0};
    vecs[3] = '{32'h12345678, 5'd11, 2'd3, 32'h3C0B1234, 32'h356B5678};
    vecs[4] = '{32'h00007FFF, 5'd1,  2'd0, 32'h24017FFF, 32'h0};
    vecs[5] = '{32'h00008000, 5'd2,  2'd1, 32'h34028000, 32'h0};
    vecs[6] = '{32'hFFFF0000, 5'd31, 2'd2, 32'h3C1FFFFF, 32'h0};
    vecs[7] = '{32'h00000000, 5'd3,  2'd0, 32'h24030000, 32'h0};
    vecs[8] = '{32'h80000001, 5'd4,  2'd3, 32'h3C048000, 32'h34840001};
    vecs[9] = '{32'hFFFFFFFF, 5'd5,  2'd0, 32'h2405FFFF, 32'h0};

    reset = 1'b1;
    in_valid = 1'b0; in_value = 32'h0; in_rt = 5'd0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_value2 = 32'h0; in_rt2 = 5'd0; out_ready2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_kind", {30'd0, out_kind}, 32'd0);
    chk("rst_count", {16'd0, word_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // ALLOW_ADDIU=0 instance: a sign-extendable value must fall back to lui+ori
    in_valid2 = 1'b1; in_value2 = 32'hFFFF8000; in_rt2 = 5'd8;
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("na_instr1", out_instr2, 32'h3C08FFFF);
    chk("na_kind", {30'd0, out_kind2}, 32'd3);
    chk("na_last1", {31'd0, out_last2}, 32'd0);
    @(negedge clk);
    chk("na_instr2", out_instr2, 32'h35088000);
    chk("na_last2", {31'd0, out_last2}, 32'd1);
    @(negedge clk);
    chk("na_idle", {31'd0, out_valid2}, 32'd0);
    chk("na_count", {16'd0, word_count2}, 32'd2);
    in_valid2 = 1'b1; in_value2 = 32'h00007FFF; in_rt2 = 5'd1;
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("na_ori_instr", out_instr2, 32'h34017FFF);
    chk("na_ori_kind", {30'd0, out_kind2}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // $zero target is consumed silently
    in_valid = 1'b1; in_value = 32'h12345678; in_rt = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("z_valid", {31'd0, out_valid}, 32'd0);
    chk("z_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("z_valid2", {31'd0, out_valid}, 32'd0);
    chk("z_count", {16'd0, word_count}, exp_count);

    // back-pressure on both words of a lui+ori pair
    in_valid = 1'b1; in_value = 32'h12345678; in_rt = 5'd11; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("st1_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("st1_instr_c%0d", c), out_instr, 32'h3C0B1234);
      chk($sformatf("st1_last_c%0d", c), {31'd0, out_last}, 32'd0);
      chk($sformatf("st1_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    chk("st1_count", {16'd0, word_count}, exp_count);
    out_ready = 1'b1;
    @(negedge clk);
    exp_count++;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("st2_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("st2_instr_c%0d", c), out_instr, 32'h356B5678);
      chk($sformatf("st2_last_c%0d", c), {31'd0, out_last}, 32'd1);
      chk($sformatf("st2_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    chk("st2_count", {16'd0, word_count}, exp_count);
    out_ready = 1'b1;
    @(negedge clk);
    exp_count++;
    chk("st_done_valid", {31'd0, out_valid}, 32'd0);
    chk("st_done_ready", {31'd0, in_ready}, 32'd1);
    chk("st_done_count", {16'd0, word_count}, exp_count);

    // reset while the second word is pending
    in_valid = 1'b1; in_value = 32'h12345678; in_rt = 5'd11;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mr_pre_instr", out_instr, 32'h356B5678);
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_count", {16'd0, word_count}, 32'd0);
    chk("mr_instr", out_instr, 32'h0);
    exp_count = 0;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mr_after_valid_c%0d", c), {31'd0, out_valid}, 32'd0);
      chk($sformatf("mr_after_ready_c%0d", c), {31'd0, in_ready}, 32'd1);
    end
    chk("mr_after_count", {16'd0, word_count}, 32'd0);

    run_vec(20, vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
